// File: rtl/real_scatter_pkg.sv
// Shared definitions for the real-valued scatter sequencer.
//   state_e   : controller states (idle, single targeted write, broadcast sweep)
//   sel_width : channel-address width for a given channel count (minimum 1 bit)
package real_scatter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SWEEP
    } state_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/real_scatter_seq.sv
// Clocked inverse of the real summing primitive. The block accepts one real sample
// per valid/ready handshake and writes scaled copies of it to no_sig held real
// outputs. A transaction writes either one addressed channel, or all channels
// in order at one channel per clock.
// Ports:
//   clk, rstn        rising-edge clock, asynchronous active-low reset
//   enable           run/freeze control (tie high when not used)
//   in_valid/in_ready  sample handshake; in, sel, bcast are sampled on accept
//   scale[no_sig]    per-channel gain, sampled on the edge that writes the channel
//   out[no_sig]      held outputs
//   out_upd          one-hot strobe for the channel written at the last edge
//   busy             a transaction is in progress
//   done             one-cycle pulse with the final write of a transaction
//   err              one-cycle pulse when a targeted sel >= no_sig was dropped
module real_scatter_seq
    import real_scatter_pkg::*;
#(
    parameter int unsigned no_sig = 2,
    parameter int unsigned SEL_W  = sel_width(no_sig)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  real               in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              bcast,
    input  real               scale [no_sig],
    output real               out [no_sig],
    output logic [no_sig-1:0] out_upd,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   sel_r_q;
    real                in_r_q;
    real                out_q [no_sig];
    logic [no_sig-1:0]  out_upd_q, out_upd_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               sel_ok;
    logic               idx_last;
    logic               wr_en;
    logic [SEL_W-1:0]   wr_idx;

    assign in_ready = enable && (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign sel_ok   = (32'(sel) < no_sig);
    assign idx_last = (32'(idx_q) == no_sig - 1);

    // State register, sweep index and accepted-sample latches
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sel_r_q <= '0;
            in_r_q  <= 0.0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                in_r_q  <= in;
                sel_r_q <= sel;
            end
        end
    end

    // Next-state logic; enable=0 holds both state and sweep index
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (bcast)       state_d = ST_SWEEP;
                        else if (sel_ok) state_d = ST_WRITE;
                    end
                end
                ST_WRITE: state_d = ST_IDLE;
                ST_SWEEP: begin
                    if (idx_last) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode: which channel is written at the coming edge, plus strobes
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        out_upd_d = '0;
        if (enable) begin
            unique case (state_q)
                ST_IDLE: err_d = accept && !bcast && !sel_ok;
                ST_WRITE: begin
                    wr_en  = 1'b1;
                    wr_idx = sel_r_q;
                    done_d = 1'b1;
                end
                ST_SWEEP: begin
                    wr_en  = 1'b1;
                    wr_idx = idx_q;
                    done_d = idx_last;
                end
                default: ;
            endcase
        end
        for (int unsigned i = 0; i < no_sig; i++) begin
            out_upd_d[i] = wr_en && (wr_idx == SEL_W'(i));
        end
    end

    // Held output array; scale is sampled only on the write edge of each channel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < no_sig; i++) begin
                out_q[i] <= 0.0;
            end
            out_upd_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < no_sig; i++) begin
                if (out_upd_d[i]) begin
                    out_q[i] <= scale[i] * in_r_q;
                end
            end
            out_upd_q <= out_upd_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign out     = out_q;
    assign out_upd = out_upd_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
